// File: rtl/side_ch_s_axis_rx.sv
// Side-channel PS-to-PL AXI-Stream receiver: slave stream into a FIFO, popped by PL control logic.
// Optional TLAST/beat-count consistency flag enabled by defining SIDE_CH_RX_TLAST_CHECK_EN.
module side_ch_s_axis_rx #(
  parameter integer C_S_AXIS_TDATA_WIDTH   = 64,
  parameter integer MAX_NUM_DMA_SYMBOL     = 8192,
  parameter integer MAX_BIT_NUM_DMA_SYMBOL = 14
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESETN,
  input  logic                                s_axis_endless_mode,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   S_AXIS_NUM_DMA_SYMBOL,
  output logic                                s_axis_state,
  output logic                                s_axis_tlast_err,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     data_to_pl,
  input  logic                                pl_ask_data,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   s_axis_data_count,
  output logic                                emptyn_to_pl,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID
);

  localparam integer ADDR_W = $clog2(MAX_NUM_DMA_SYMBOL);
  localparam integer CW     = MAX_BIT_NUM_DMA_SYMBOL;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_NUM_DMA_SYMBOL);

  // Handshake: a beat transfers on a rising edge where S_AXIS_TVALID and S_AXIS_TREADY are
  // both 1; a word pops on a rising edge where pl_ask_data and emptyn_to_pl are both 1.

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                          state, state_nxt;
  logic [CW-1:0]                   count, count_nxt;
  logic [CW-1:0]                   beat_cnt;
  logic [ADDR_W-1:0]               wr_ptr, rd_ptr;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] mem [0:MAX_NUM_DMA_SYMBOL-1];
  logic                            tready;
  logic                            push, pop;
  logic                            last_beat;
  logic                            unused_tstrb;

  assign unused_tstrb = ^S_AXIS_TSTRB;

  assign push      = S_AXIS_TVALID & tready;
  assign pop       = pl_ask_data & (count != '0);
  assign last_beat = (beat_cnt == S_AXIS_NUM_DMA_SYMBOL) | S_AXIS_TLAST;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (S_AXIS_TVALID) state_nxt = RECV;
      RECV:    if (push && !s_axis_endless_mode && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  // TREADY looks ahead at the next state and count so it never asserts into a full FIFO.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state    <= IDLE;
      tready   <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state  <= state_nxt;
      tready <= (state_nxt == RECV) && (count_nxt != FULL_CNT);
      count  <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (state == IDLE) begin
        if (S_AXIS_TVALID) beat_cnt <= '0;
      end else if (push && (s_axis_endless_mode || !last_beat)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) mem[wr_ptr] <= S_AXIS_TDATA;
  end

`ifdef SIDE_CH_RX_TLAST_CHECK_EN
  logic tlast_err;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      tlast_err <= 1'b0;
    end else if (push && !s_axis_endless_mode) begin
      // Early TLAST, or the final counted beat without TLAST.
      if ((S_AXIS_TLAST && (beat_cnt < S_AXIS_NUM_DMA_SYMBOL)) ||
          (!S_AXIS_TLAST && (beat_cnt == S_AXIS_NUM_DMA_SYMBOL)))
        tlast_err <= 1'b1;
    end
  end

  assign s_axis_tlast_err = tlast_err;
`else
  assign s_axis_tlast_err = 1'b0;
`endif

  assign S_AXIS_TREADY     = tready;
  assign s_axis_state      = (state == RECV);
  assign s_axis_data_count = count;
  assign emptyn_to_pl      = (count != '0);
  assign data_to_pl        = mem[rd_ptr];

endmodule
